// File: rtl/logIP_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logIP_pkg
//  Description : Shared types and helpers for the capture controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package logIP_pkg;

    // Capture/readback sequencer states, explicitly 3-bit encoded.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        DELAY   = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        SEND    = 3'd5
    } capture_state_t;

    // Width of the sample counters (read count and post-trigger delay).
    localparam int CNT_W = 18;

    // Command fields carry count/4 - 1. The largest delay field wraps to 0
    // in CNT_W bits; the down-counter then runs a full 2^CNT_W writes, which
    // is exactly the requested count.
    function automatic logic [CNT_W-1:0] field_to_cnt(input logic [15:0] field);
        return {field, 2'b00} + CNT_W'(4);
    endfunction

endpackage : logIP_pkg
`default_nettype wire

// File: rtl/capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : capture_ctrl
//  Description : Ring-buffer capture controller. Writes samples into an
//                external RAM while armed, captures a programmed number of
//                post-trigger samples, then reads a programmed number of
//                samples back newest-first and hands them to the transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
module capture_ctrl
    import logIP_pkg::*;
#(
    parameter  int MEM_DEPTH = 4096,
    localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       cmd_i,
    input  logic              set_cnt_i,
    input  logic              arm_i,
    input  logic              run_i,
    input  logic              stb_i,
    input  logic [31:0]       smpls_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic [31:0]       tx_data_o,
    output logic              tx_stb_o,
    input  logic              tx_busy_i,
    output logic              armed_o,
    output logic              done_o
);

    // Any read field at or above this value asks for more words than the RAM holds.
    localparam logic [31:0]      RD_CLAMP_FIELD = 32'(MEM_DEPTH / 4);
    localparam logic [CNT_W-1:0] DEPTH_CNT      = CNT_W'(MEM_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_RESET      = CNT_W'(4);
    localparam logic [ADDR_W-1:0] PTR_ONE       = ADDR_W'(1);

    capture_state_t    state_q,     state_d;
    logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [CNT_W-1:0]  read_cnt_q,  read_cnt_d;
    logic [CNT_W-1:0]  delay_cnt_q, delay_cnt_d;
    logic [31:0]       tx_data_q,   tx_data_d;
    logic              done_q,      done_d;
    logic              wr_fire_w;

    // Next-state logic for the sequencer, pointers, counters and tx holding register.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        read_cnt_d  = read_cnt_q;
        delay_cnt_d = delay_cnt_q;
        tx_data_d   = tx_data_q;
        done_d      = 1'b0;
        wr_fire_w   = 1'b0;

        case (state_q)
            IDLE: begin
                if (set_cnt_i) begin
                    delay_cnt_d = field_to_cnt(cmd_i[31:16]);
                    if ({16'd0, cmd_i[15:0]} >= RD_CLAMP_FIELD) begin
                        read_cnt_d = DEPTH_CNT;
                    end else begin
                        read_cnt_d = field_to_cnt(cmd_i[15:0]);
                    end
                end
                if (arm_i) begin
                    state_d  = ARMED;
                    wr_ptr_d = '0;
                end
            end

            ARMED: begin
                if (arm_i) begin
                    // Re-arm: restart at address 0 and drop this cycle's sample.
                    wr_ptr_d = '0;
                end else begin
                    if (stb_i) begin
                        wr_fire_w = 1'b1;
                        wr_ptr_d  = wr_ptr_q + PTR_ONE;
                    end
                    if (run_i) begin
                        state_d = DELAY;
                        // A sample arriving with the trigger is the first post-trigger one.
                        cnt_d   = stb_i ? (delay_cnt_q - CNT_ONE) : delay_cnt_q;
                    end
                end
            end

            DELAY: begin
                if (arm_i) begin
                    state_d  = ARMED;
                    wr_ptr_d = '0;
                end else if (stb_i) begin
                    wr_fire_w = 1'b1;
                    wr_ptr_d  = wr_ptr_q + PTR_ONE;
                    cnt_d     = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        // Newest sample is the one being written this cycle.
                        state_d  = RD_REQ;
                        rd_ptr_d = wr_ptr_q;
                        cnt_d    = read_cnt_q;
                    end
                end
            end

            RD_REQ: begin
                state_d = RD_WAIT;
            end

            RD_WAIT: begin
                tx_data_d = mem_rdata_i;
                state_d   = SEND;
            end

            SEND: begin
                if (!tx_busy_i) begin
                    rd_ptr_d = rd_ptr_q - PTR_ONE;
                    cnt_d    = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            read_cnt_q  <= CNT_RESET;
            delay_cnt_q <= CNT_RESET;
            tx_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            read_cnt_q  <= read_cnt_d;
            delay_cnt_q <= delay_cnt_d;
            tx_data_q   <= tx_data_d;
            done_q      <= done_d;
        end
    end

    // RAM port: write address during captures, read address in RD_REQ, else idle at 0.
    always_comb begin
        mem_we_o    = wr_fire_w;
        mem_wdata_o = wr_fire_w ? smpls_i : 32'd0;
        if (wr_fire_w) begin
            mem_addr_o = wr_ptr_q;
        end else if (state_q == RD_REQ) begin
            mem_addr_o = rd_ptr_q;
        end else begin
            mem_addr_o = '0;
        end
    end

    assign tx_data_o = tx_data_q;
    assign tx_stb_o  = (state_q == SEND) && !tx_busy_i;
    assign armed_o   = (state_q == ARMED) || (state_q == DELAY);
    assign done_o    = done_q;

endmodule : capture_ctrl
`default_nettype wire

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Sits directly downstream of the trigger unit. It consumes the trigger `run` flag plus the sampler strobe and sample bus.
- Continuously writes samples into an external ring-buffer RAM while armed. After `run`, it captures a programmed number of post-trigger samples.
- It then reads a programmed number of samples back, newest first, and hands them word by word to the UART transmitter.

Parameters:
- MEM_DEPTH, 4096, sample RAM depth in 32-bit words; power of two, min 16.
- ADDR_W, $clog2(MEM_DEPTH), RAM address width (derived, not overridden).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active high
- cmd_i  in  32  command word; [15:0] read count/4 - 1, [31:16] delay count/4 - 1
- set_cnt_i  in  1  flag, latch read and delay counts from cmd_i
- arm_i  in  1  flag, arm capture
- run_i  in  1  trigger fired (from trigger block)
- stb_i  in  1  flag, new sample valid
- smpls_i  in  32  sampled channels
- mem_we_o  out  1  RAM write enable
- mem_addr_o  out  ADDR_W  RAM address (read and write)
- mem_wdata_o  out  32  RAM write data
- mem_rdata_i  in  32  RAM read data, valid 1 cycle after address
- tx_data_o  out  32  word to transmitter
- tx_stb_o  out  1  1-cycle pulse, tx_data_o valid
- tx_busy_i  in  1  transmitter busy; no tx_stb_o while high
- armed_o  out  1  high in ARMED or DELAY
- done_o  out  1  1-cycle pulse after last word sent

Behaviour:
- Clock and reset: one clock `clk_i`. `rst_i` is asynchronous and active high.
- On reset:
  - all outputs are 0;
  - state is IDLE;
  - wr_ptr and rd_ptr are 0;
  - read_cnt and delay_cnt are 4 (field value 0).

Count latch (`set_cnt_i`):
- Latched only in IDLE; ignored in all other states.
- read_cnt = (cmd_i[15:0]+1)*4 and delay_cnt = (cmd_i[31:16]+1)*4, both 18-bit.
- read_cnt is clamped to MEM_DEPTH.

State IDLE:
- arm_i -> ARMED; wr_ptr <= 0.

State ARMED:
- On each stb_i: mem_we_o=1, mem_addr_o=wr_ptr, mem_wdata_o=smpls_i (combinational from the current cycle); wr_ptr++ with wrap at MEM_DEPTH.
- run_i -> DELAY with cnt <= delay_cnt.
- If stb_i coincides with run_i, that sample is written and counts as the first post-trigger sample: cnt <= delay_cnt-1.

State DELAY:
- On each stb_i: write as in ARMED and cnt--.
- When the write that brings cnt to 0 occurs -> RD_REQ, with rd_ptr <= wr_ptr_after_write - 1 (newest sample) and cnt <= read_cnt.
- run_i is ignored.

Re-arm:
- arm_i in ARMED or DELAY restarts ARMED: wr_ptr <= 0, and the pending write is dropped.
- arm_i in read states is ignored.

Readback states:
- RD_REQ: drive mem_addr_o=rd_ptr -> RD_WAIT.
- RD_WAIT: register mem_rdata_i into tx_data_o -> SEND.
- SEND: when tx_busy_i=0, pulse tx_stb_o and hold tx_data_o; then rd_ptr-- (wrap 0 -> MEM_DEPTH-1) and cnt--.
  - If cnt becomes 0 -> IDLE with done_o pulse.
  - Otherwise -> RD_REQ.
- Throughput: at most 1 word per 3 cycles with tx_busy_i low.

Other rules:
- tx_data_o holds its last value between pulses.
- mem_we_o is never high outside ARMED/DELAY.
- Wrap: while ARMED, samples overwrite the oldest data indefinitely. If fewer than read_cnt samples were written, stale RAM contents are sent; no error is flagged.
- Reset mid-operation: immediate return to IDLE; a pending tx_stb_o or done_o is never emitted.

Decomposition:
- logIP_pkg: capture_state_t enum {IDLE, ARMED, DELAY, RD_REQ, RD_WAIT, SEND}; constant CNT_W=18.
- No sub-module; the RAM stays external (instantiated by the core top).

Test Plan:
- Reset defaults: assert rst_i mid-SEND -> all outputs 0 within the same cycle; state IDLE; counts back to 4.
- Basic capture:
  - setup: set_cnt cmd=0x0000_0000 (read 4, delay 4); arm; stb with smpls 1,2,3,...; run_i after sample 10;
  - writes: exactly 4 further writes (11..14), then no mem_we_o;
  - readback: tx words 14,13,12,11 in that order; done_o once.
- Coincident run/stb: run_i high in the same cycle as the stb carrying sample 7, delay 4 -> last written sample is 10; first tx word is 10.
- Wrap-around: MEM_DEPTH=16; 40 samples before run; delay 4 and read 16 -> 16 consecutive descending words ending at 44; addresses wrap 15 -> 0 on writes and 0 -> 15 on reads.
- Backpressure: hold tx_busy_i high 20 cycles during SEND -> tx_stb_o stays low, tx_data_o stable, no words lost; pulses resume when busy drops.
- Re-arm and ignores:
  - arm_i during DELAY -> wr_ptr restarts at 0 and delay is discarded;
  - set_cnt_i during DELAY -> ignored (read count unchanged);
  - clamp: cmd read field 0xFFFF -> exactly MEM_DEPTH words sent.
